// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single instruction/data memory port between the instruction
//   fetch requester and the load/store requester. One transaction is
//   outstanding at a time: a winner is granted in IDLE, its request is held on
//   the memory port until accepted (REQ), then the response is waited for and
//   routed back to the owner as a one-cycle pulse (RSP).
//
//   Address and data are the CPU's 32-bit address and data words.
//
// Parameters
//   DATA_PRIORITY  1: load/store always wins contention
//                  0: round-robin between fetch and load/store
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   if_req_valid/addr/ready        fetch request handshake
//   if_flush                       discard any in-flight fetch response
//   if_rsp_valid/data              fetch response (one-cycle pulse)
//   d_req_valid/addr/we/wdata/be   load/store request
//   d_req_ready                    load/store request accepted
//   d_rsp_valid/data               load data or store ack (data 0 for stores)
//   mem_valid/addr/we/wdata/be     memory request, held stable until mem_ready
//   mem_ready                      memory accepts the request
//   mem_rsp_valid/data             memory response
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    input  logic        if_flush,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_be,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t      state_reg;
    logic        owner_d_reg;     // 1 = load/store owns the transaction
    logic        rr_d_reg;        // 1 = data is favoured on the next contention
    logic        drop_reg;        // suppress the fetch response of this transaction
    logic        mem_valid_reg;
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        if_rsp_valid_reg;
    logic [31:0] if_rsp_data_reg;
    logic        d_rsp_valid_reg;
    logic [31:0] d_rsp_data_reg;

    logic        grant_if;
    logic        grant_d;

    // Grant is combinational so the requester sees ready in the same cycle it
    // presents valid; held low while in reset so nothing is accepted then.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst && state_reg == IDLE) begin
            if (if_req_valid && d_req_valid) begin
                if (DATA_PRIORITY || rr_d_reg) begin
                    grant_d = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            owner_d_reg      <= 1'b0;
            rr_d_reg         <= 1'b0;
            drop_reg         <= 1'b0;
            mem_valid_reg    <= 1'b0;
            addr_reg         <= '0;
            we_reg           <= 1'b0;
            wdata_reg        <= '0;
            be_reg           <= '0;
            if_rsp_valid_reg <= 1'b0;
            if_rsp_data_reg  <= '0;
            d_rsp_valid_reg  <= 1'b0;
            d_rsp_data_reg   <= '0;
        end else begin
            // Response valids are single-cycle pulses; data holds.
            if_rsp_valid_reg <= 1'b0;
            d_rsp_valid_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        state_reg     <= REQ;
                        mem_valid_reg <= 1'b1;
                        owner_d_reg   <= grant_d;
                        addr_reg      <= grant_d ? d_req_addr : if_req_addr;
                        we_reg        <= grant_d & d_req_we;
                        wdata_reg     <= grant_d ? d_req_wdata : 32'h0;
                        be_reg        <= grant_d ? d_req_be : 4'hF;
                        // Favour whoever was not granted this time.
                        rr_d_reg      <= grant_if;
                        drop_reg      <= 1'b0;
                    end
                end
                REQ: begin
                    if (!owner_d_reg && if_flush) begin
                        drop_reg <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_valid_reg <= 1'b0;
                        state_reg     <= RSP;
                    end
                end
                RSP: begin
                    if (!owner_d_reg && if_flush) begin
                        drop_reg <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        state_reg <= IDLE;
                        drop_reg  <= 1'b0;
                        if (owner_d_reg) begin
                            d_rsp_valid_reg <= 1'b1;
                            d_rsp_data_reg  <= we_reg ? 32'h0 : mem_rsp_data;
                        end else if (!drop_reg && !if_flush) begin
                            // A flush arriving with the response also drops it.
                            if_rsp_valid_reg <= 1'b1;
                            if_rsp_data_reg  <= mem_rsp_data;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;
    assign if_rsp_valid = if_rsp_valid_reg;
    assign if_rsp_data  = if_rsp_data_reg;
    assign d_rsp_valid  = d_rsp_valid_reg;
    assign d_rsp_data   = d_rsp_data_reg;
    assign mem_valid    = mem_valid_reg;
    assign mem_addr     = addr_reg;
    assign mem_we       = we_reg;
    assign mem_wdata    = wdata_reg;
    assign mem_be       = be_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. The main instance uses data priority and
//   talks to a behavioural memory with optional accept stalls; a second
//   instance in round-robin mode sits on an always-ready one-cycle memory.
//   Expected responses are queued at grant time and compared when the DUT
//   pulses its response valid.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_flush = 1'b0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0;
    logic [31:0] d_req_addr = '0;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_wdata = '0;
    logic [3:0]  d_req_be = '0;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;

    // Round-robin instance
    logic        rr_if_valid = 1'b0;
    logic        rr_d_valid = 1'b0;
    logic        rr_if_ready;
    logic        rr_d_ready;
    logic        rr_if_rsp_valid;
    logic [31:0] rr_if_rsp_data;
    logic        rr_d_rsp_valid;
    logic [31:0] rr_d_rsp_data;
    logic        rr_mem_valid;
    logic [31:0] rr_mem_addr;
    logic        rr_mem_we;
    logic [31:0] rr_mem_wdata;
    logic [3:0]  rr_mem_be;
    logic        rr_mem_rsp_valid = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] mem_arr[logic [31:0]];

    bit mem_auto = 1'b1;
    int stall_left = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_PRIORITY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    mem_arbiter #(.DATA_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .if_req_valid(rr_if_valid), .if_req_addr(32'h0000_1000), .if_req_ready(rr_if_ready),
        .if_flush(1'b0), .if_rsp_valid(rr_if_rsp_valid), .if_rsp_data(rr_if_rsp_data),
        .d_req_valid(rr_d_valid), .d_req_addr(32'h0000_3000), .d_req_we(1'b0),
        .d_req_wdata(32'h0), .d_req_be(4'hF), .d_req_ready(rr_d_ready),
        .d_rsp_valid(rr_d_rsp_valid), .d_rsp_data(rr_d_rsp_data),
        .mem_valid(rr_mem_valid), .mem_addr(rr_mem_addr), .mem_we(rr_mem_we),
        .mem_wdata(rr_mem_wdata), .mem_be(rr_mem_be), .mem_ready(rr_mem_valid),
        .mem_rsp_valid(rr_mem_rsp_valid), .mem_rsp_data(32'h1234_5678)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural memory: handshake sampled mid-cycle, response driven one
    // cycle later; accept may be stalled by stall_left cycles.
    always begin
        bit          hs;
        bit          hs_we;
        logic [31:0] hs_addr;
        logic [31:0] hs_wdata;
        logic [3:0]  hs_be;
        logic [31:0] merged;
        bit          rr_hs;
        @(negedge clk);
        hs       = mem_valid && mem_ready;
        hs_we    = mem_we;
        hs_addr  = mem_addr;
        hs_wdata = mem_wdata;
        hs_be    = mem_be;
        rr_hs    = rr_mem_valid;
        @(posedge clk);
        #1;
        rr_mem_rsp_valid = rr_hs;
        if (mem_auto) begin
            if (hs && hs_we) begin
                merged = mem_read(hs_addr);
                for (int b = 0; b < 4; b++) begin
                    if (hs_be[b]) merged[8*b +: 8] = hs_wdata[8*b +: 8];
                end
                mem_arr[hs_addr] = merged;
            end
            mem_rsp_valid = hs;
            mem_rsp_data  = hs ? (hs_we ? 32'hA5A5_A5A5 : mem_read(hs_addr)) : 32'h0;
            if (mem_valid && stall_left > 0) begin
                mem_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                mem_ready = mem_valid;
            end
        end
    end

    // Response scoreboard
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (!rst && if_rsp_valid) begin
            $display("if  rsp data=0x%08h", if_rsp_data);
            check("if_rsp_expected", {31'b0, if_q.size() != 0}, 32'd1);
            if (if_q.size() != 0) begin
                exp_v = if_q.pop_front();
                check("if_rsp_data", if_rsp_data, exp_v);
            end
        end
        if (!rst && d_rsp_valid) begin
            $display("d   rsp data=0x%08h", d_rsp_data);
            check("d_rsp_expected", {31'b0, d_q.size() != 0}, 32'd1);
            if (d_q.size() != 0) begin
                exp_v = d_q.pop_front();
                check("d_rsp_data", d_rsp_data, exp_v);
            end
        end
    end

    // One complete transaction on the main instance with an immediate memory.
    task automatic do_txn(input bit is_d, input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input bit flush_rsp, input bit expect_rsp);
        bit got = 1'b0;
        if (is_d) begin
            d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we;
            d_req_wdata = wdata; d_req_be = be;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (is_d ? d_req_ready : if_req_ready) got = 1'b1;
            else tick();
        end
        check("grant_seen", {31'b0, got}, 32'd1);
        if (got && expect_rsp) begin
            if (is_d) d_q.push_back(we ? 32'h0 : mem_read(addr));
            else if_q.push_back(mem_read(addr));
        end
        tick();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        tick();
        if (flush_rsp) if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        #1;
        check(is_d ? "d_rsp_valid_t3" : "if_rsp_valid_t3",
              {31'b0, is_d ? d_rsp_valid : if_rsp_valid}, {31'b0, expect_rsp});
        tick();
    endtask

    initial begin
        int n;
        mem_arr[32'h0000_0100] = 32'h0050_0093;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", {28'b0, mem_be}, 32'h0);
        check("rst_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
        check("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        check("rst_if_req_ready", {31'b0, if_req_ready}, 32'd0);
        tick();
        rst = 1'b0;

        // Single fetch with cycle-accurate latency
        tick();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0100;
        #1;
        check("t0_if_req_ready", {31'b0, if_req_ready}, 32'd1);
        check("t0_d_req_ready", {31'b0, d_req_ready}, 32'd0);
        if_q.push_back(32'h0050_0093);
        tick();
        if_req_valid = 1'b0;
        #1;
        check("t1_mem_valid", {31'b0, mem_valid}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h0000_0100);
        check("t1_mem_we", {31'b0, mem_we}, 32'd0);
        check("t1_mem_be", {28'b0, mem_be}, 32'hF);
        check("t1_mem_wdata", mem_wdata, 32'h0);
        tick();
        #1;
        check("t2_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("t2_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
        tick();
        #1;
        check("t3_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
        check("t3_if_rsp_data", if_rsp_data, 32'h0050_0093);
        check("t3_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        tick();
        #1;
        check("t4_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
        check("t4_if_rsp_data_hold", if_rsp_data, 32'h0050_0093);

        // Data priority under continuous contention
        tick();
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_we = 1'b0;
        d_req_wdata = 32'h0; d_req_be = 4'hF;
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            #1;
            if (if_req_ready || d_req_ready) begin
                check("dp1_grant_data", {31'b0, d_req_ready}, 32'd1);
                check("dp1_no_if_grant", {31'b0, if_req_ready}, 32'd0);
                if (d_req_ready) d_q.push_back(mem_read(32'h0000_2000));
                if (if_req_ready) if_q.push_back(mem_read(32'h0));
                n++;
            end
            tick();
        end
        check("dp1_three_grants", n, 32'd3);
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (4) tick();

        // Round-robin instance alternates starting from IF
        rr_if_valid = 1'b1;
        rr_d_valid  = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (rr_if_ready || rr_d_ready) begin
                check($sformatf("rr_grant%0d_d", n), {31'b0, rr_d_ready}, n % 2);
                check($sformatf("rr_grant%0d_if", n), {31'b0, rr_if_ready}, (n + 1) % 2);
                n++;
            end
            tick();
        end
        check("rr_four_grants", n, 32'd4);
        rr_if_valid = 1'b0;
        rr_d_valid  = 1'b0;
        repeat (4) tick();

        // Store with memory accept stalled 3 cycles
        stall_left  = 3;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_0040; d_req_we = 1'b1;
        d_req_wdata = 32'hDEAD_BEEF; d_req_be = 4'b0011;
        #1;
        check("st_d_req_ready", {31'b0, d_req_ready}, 32'd1);
        d_q.push_back(32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                d_req_valid = 1'b0; d_req_addr = 32'hFFFF_FFFC;
                d_req_wdata = 32'h0; d_req_we = 1'b0; d_req_be = 4'h0;
            end
            #1;
            check($sformatf("st_mem_valid_c%0d", k), {31'b0, mem_valid}, 32'd1);
            check($sformatf("st_mem_addr_c%0d", k), mem_addr, 32'h0000_0040);
            check($sformatf("st_mem_we_c%0d", k), {31'b0, mem_we}, 32'd1);
            check($sformatf("st_mem_wdata_c%0d", k), mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("st_mem_be_c%0d", k), {28'b0, mem_be}, 32'h3);
        end
        tick();
        #1;
        check("st_mem_valid_after", {31'b0, mem_valid}, 32'd0);
        check("st_d_rsp_valid_early", {31'b0, d_rsp_valid}, 32'd0);
        tick();
        #1;
        check("st_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd1);
        check("st_d_rsp_data", d_rsp_data, 32'h0);
        tick();

        // Load back the partially written word
        do_txn(1'b1, 32'h0000_0040, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
        check("ld_merged_word", d_rsp_data, 32'h5A5A_BEEF);

        // Flushed fetch, then a normal fetch
        do_txn(1'b0, 32'h0000_0200, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_0104, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);

        // Flush has no effect on a data transaction
        do_txn(1'b1, 32'h0000_0080, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1);

        // Reset in REQ abandons the transaction
        d_req_valid = 1'b1; d_req_addr = 32'h0000_0300; d_req_we = 1'b0; d_req_be = 4'hF;
        #1;
        check("rq_d_req_ready", {31'b0, d_req_ready}, 32'd1);
        tick();
        d_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rq_in_req", {31'b0, mem_valid}, 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("rq_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rq_mem_addr", mem_addr, 32'h0);
        check("rq_mem_we", {31'b0, mem_we}, 32'd0);
        check("rq_mem_wdata", mem_wdata, 32'h0);
        check("rq_mem_be", {28'b0, mem_be}, 32'h0);
        check("rq_if_rsp_data", if_rsp_data, 32'h0);
        check("rq_d_rsp_data", d_rsp_data, 32'h0);
        check("rq_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        check("rq_d_req_ready", {31'b0, d_req_ready}, 32'd0);
        mem_auto = 1'b0;
        tick();
        mem_ready     = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        #1;
        check("stray0_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("stray1_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        check("stray1_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
        tick();
        #1;
        check("stray2_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        mem_auto = 1'b1;
        tick();

        // Still operational afterwards
        do_txn(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        repeat (3) tick();
        check("if_q_drained", if_q.size(), 32'd0);
        check("d_q_drained", d_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout observed, finish required");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single instruction/data memory port between the instruction-fetch requester (PC-driven fetch) and the load/store requester. Grants one requester at a time and holds the memory request stable until accepted. Routes the memory response back to the owner, supporting one outstanding transaction. Sits between the pipeline stages and the memory interface; its IF fetch response can be discarded on a branch redirect.

## Interface
- DATA_PRIORITY, 1: 1 = load/store always wins contention; 0 = round-robin between IF and data.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- if_req_valid  in  1  fetch request pending
- if_req_addr  in  rvcpu::addr_t  fetch address (PC)
- if_req_ready  out  1  fetch request accepted this cycle
- if_flush  in  1  discard any in-flight fetch response
- if_rsp_valid  out  1  fetch data valid (one-cycle pulse)
- if_rsp_data  out  rvcpu::data_t  fetched opcode word
- d_req_valid  in  1  load/store request pending
- d_req_addr  in  rvcpu::addr_t  data address
- d_req_we  in  1  1 = store, 0 = load
- d_req_wdata  in  rvcpu::data_t  store data
- d_req_be  in  4  byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  load data / store ack valid (one-cycle pulse)
- d_rsp_data  out  rvcpu::data_t  load data; 0 for stores
- mem_valid  out  1  memory request valid
- mem_addr, mem_we, mem_wdata, mem_be  out  addr_t/1/data_t/4  memory request fields
- mem_ready  in  1  memory accepts request this cycle
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  rvcpu::data_t  memory response data

## Operation
- FSM states: IDLE, REQ, RSP. Reset → IDLE.
- IDLE: arbitrate among asserted valids. Exactly one of if_req_ready/d_req_ready is driven high (combinationally) for the winner; never both. Winner's addr/we/wdata/be are captured into request registers; owner flag is set; go to REQ. IF requests register we=0, be=4'hF, wdata=0.
- Arbitration: DATA_PRIORITY=1 → data wins. DATA_PRIORITY=0 → rr pointer; on contention, grant the requester not granted last. The pointer updates on every grant; reset value favours IF.
- REQ: mem_valid=1 with fields held stable from the registers. When mem_ready=1, go to RSP.
- RSP: wait for mem_rsp_valid. When it is high, register mem_rsp_data. Next cycle, pulse the owner's rsp_valid, and go to IDLE in the same edge.
- mem_rsp_valid outside RSP is ignored. Memory must not respond in the same cycle it asserts mem_ready.
- Flush: a drop flag is set if if_flush=1 while owner=IF in REQ or RSP, or in the cycle the IF response is registered. When set, if_rsp_valid is suppressed for that transaction; the memory transaction still completes. The flag clears on return to IDLE. if_flush in IDLE has no effect. if_flush never affects data transactions.
- Store completion: d_rsp_valid pulses with d_rsp_data=0.

## Timing
- Reset values: state=IDLE, mem_valid=0, mem_addr=0, mem_we=0, mem_wdata=0, mem_be=0, both req_ready=0, both rsp_valid=0, both rsp_data=0, rr→IF, drop=0.
- rst mid-transaction: next cycle IDLE with all outputs at reset values; the transaction is abandoned and no rsp_valid is produced for it.
- Latency with mem_ready immediate and a one-cycle memory: accept at cycle t, mem_valid at t+1, mem_rsp_valid at t+2, rsp_valid at t+3, next accept possible at t+3.
- Throughput: one transaction per ≥3 cycles.
- rsp_data holds its last value when rsp_valid=0.
- req_ready is low during REQ/RSP. Requesters must hold valid and fields until ready.

## Test plan
- Single fetch, addr 0x100, mem_ready immediate, mem_rsp_data 0x00500093 one cycle later → if_req_ready at t0, mem_addr=0x100 at t1, if_rsp_valid with 0x00500093 at t3, d_rsp_valid never high.
- DATA_PRIORITY=1, both valid every cycle (IF 0x0, load 0x2000) → d_req_ready always wins; three consecutive grants all data.
- DATA_PRIORITY=0, both continuously valid → grants alternate IF, D, IF, D.
- mem_ready held low 3 cycles during a store (addr 0x40, wdata 0xDEADBEEF, be 4'b0011) → mem_valid and fields stable all 4 cycles; d_rsp_valid=1 with data 0 after the ack.
- if_flush pulsed in RSP of a fetch → no if_rsp_valid; FSM returns to IDLE and the next fetch completes normally.
- rst asserted in REQ → next cycle mem_valid=0 and all outputs 0; a later stray mem_rsp_valid produces no rsp_valid.
